// File: rtl/n_channel_gate_array.sv
// n_channel_gate_array: CHANNELS independent WIDTH-bit two-operand gates with a
// run-time selectable function (OR/AND/XOR/NOR), followed by a LATENCY-deep
// valid pipeline that freezes completely while hold is high.
// Optional per-channel output activity counters are enabled by defining the
// macro GATE_ACT_CNT_EN; without it act_count is tied to zero and no counter
// or previous-value state exists.
module n_channel_gate_array #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 1,
  parameter int LATENCY  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [CHANNELS*WIDTH-1:0] b,
  input  logic [1:0]                op_sel,
  input  logic                      op_load,
  input  logic                      in_valid,
  input  logic                      hold,
  output logic [CHANNELS*WIDTH-1:0] y,
  output logic                      out_valid,
  output logic [1:0]                op_cur,
  output logic [CHANNELS*CNT_W-1:0] act_count
);

  localparam int DW = CHANNELS * WIDTH;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  op_e             op_q;
  logic [DW-1:0]   gate_res;
  logic [DW-1:0]   stage_data [LATENCY];
  logic [LATENCY-1:0] stage_valid;

  // Function register: op_load wins over hold, reset wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: state is always updated with <= so every register samples the
    // pre-edge values; a blocking = here would let later logic see the new value.
    if (reset) begin
      op_q <= OP_OR;
    end else if (op_load) begin
      op_q <= op_e'(op_sel);
    end
  end

  // Stage-0 compute: whole-vector bitwise op, so channels and bits never interact.
  always_comb begin
    // NOTE: defaulting the output first keeps this combinational even if a
    // case arm is later removed; otherwise a latch would be inferred.
    gate_res = '0;
    case (op_q)
      OP_OR:  gate_res = a | b;
      OP_AND: gate_res = a & b;
      OP_XOR: gate_res = a ^ b;
      OP_NOR: gate_res = ~(a | b);
      default: gate_res = '0;
    endcase
  end

  // Valid pipeline: shift on every edge without hold, freeze entirely with hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data stages are cleared, not just the valid bits, because y
      // must read as zero straight after reset.
      for (int i = 0; i < LATENCY; i++) begin
        stage_data[i] <= '0;
      end
      stage_valid <= '0;
    end else if (!hold) begin
      stage_data[0]  <= gate_res;
      stage_valid[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        stage_data[i]  <= stage_data[i-1];
        stage_valid[i] <= stage_valid[i-1];
      end
    end
  end

  assign y         = stage_data[LATENCY-1];
  assign out_valid = stage_valid[LATENCY-1];
  assign op_cur    = op_q;

`ifdef GATE_ACT_CNT_EN
  logic [DW-1:0]    prev_y;
  logic [CNT_W-1:0] cnt_q [CHANNELS];

  // Activity counters: count each consumed valid output whose slice changed.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_y <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        cnt_q[k] <= '0;
      end
    end else if (out_valid && !hold) begin
      prev_y <= y;
      for (int k = 0; k < CHANNELS; k++) begin
        if ((y[k*WIDTH +: WIDTH] != prev_y[k*WIDTH +: WIDTH]) &&
            (cnt_q[k] != {CNT_W{1'b1}})) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  // Pack the per-channel counters onto the output bus.
  always_comb begin
    act_count = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      act_count[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end
`else
  assign act_count = '0;
`endif

endmodule

// File: tb/tb_n_channel_gate_array.sv
// Testbench for n_channel_gate_array. Two instances run in lockstep:
//   dut0: CHANNELS=4, WIDTH=1, LATENCY=2, CNT_W=16
//   dut1: CHANNELS=2, WIDTH=8, LATENCY=4, CNT_W=2
// A behavioural model tracks accepted samples with the number of advancing
// (non-hold) edges at which they were accepted; a sample is visible once
// LATENCY-1 further advancing edges have passed.
module tb_n_channel_gate_array;

  localparam int CH0 = 4, W0 = 1, L0 = 2, CW0 = 16;
  localparam int CH1 = 2, W1 = 8, L1 = 4, CW1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset0 = 1'b1, reset1 = 1'b1;
  logic [CH0*W0-1:0]   a0 = '0, b0 = '0;
  logic [CH1*W1-1:0]   a1 = '0, b1 = '0;
  logic [1:0]          op_sel0 = '0, op_sel1 = '0;
  logic                op_load0 = 1'b0, op_load1 = 1'b0;
  logic                in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic                hold0 = 1'b0, hold1 = 1'b0;
  logic [CH0*W0-1:0]   y0;
  logic [CH1*W1-1:0]   y1;
  logic                ov0, ov1;
  logic [1:0]          opc0, opc1;
  logic [CH0*CW0-1:0]  ac0;
  logic [CH1*CW1-1:0]  ac1;

  n_channel_gate_array #(.CHANNELS(CH0), .WIDTH(W0), .LATENCY(L0), .CNT_W(CW0)) dut0 (
    .clk(clk), .reset(reset0), .a(a0), .b(b0), .op_sel(op_sel0), .op_load(op_load0),
    .in_valid(in_valid0), .hold(hold0), .y(y0), .out_valid(ov0), .op_cur(opc0),
    .act_count(ac0));

  n_channel_gate_array #(.CHANNELS(CH1), .WIDTH(W1), .LATENCY(L1), .CNT_W(CW1)) dut1 (
    .clk(clk), .reset(reset1), .a(a1), .b(b1), .op_sel(op_sel1), .op_load(op_load1),
    .in_valid(in_valid1), .hold(hold1), .y(y1), .out_valid(ov1), .op_cur(opc1),
    .act_count(ac1));

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  typedef struct {
    int          dut;
    int          stamp;
    logic [31:0] y;
  } samp_t;

  samp_t       inflight[$];
  int          adv [2];
  logic [1:0]  op_m [2];
  logic [31:0] prev_m [2];
  int          cnt_m [2][4];

  function automatic int lat(int d);   return (d == 0) ? L0 : L1;   endfunction
  function automatic int chn(int d);   return (d == 0) ? CH0 : CH1; endfunction
  function automatic int wd(int d);    return (d == 0) ? W0 : W1;   endfunction
  function automatic int cmax(int d);  return (d == 0) ? 65535 : 3; endfunction
  function automatic logic [31:0] dmask(int d);
    return (d == 0) ? 32'h0000_000F : 32'h0000_FFFF;
  endfunction

  function automatic logic [31:0] gate(int d, logic [1:0] op, logic [31:0] x, logic [31:0] z);
    logic [31:0] r;
    case (op)
      2'd0: r = x | z;
      2'd1: r = x & z;
      2'd2: r = x ^ z;
      default: r = ~(x | z);
    endcase
    return r & dmask(d);
  endfunction

  function automatic bit model_vis(input int d, output logic [31:0] yv);
    yv = '0;
    foreach (inflight[i]) begin
      if (inflight[i].dut == d && inflight[i].stamp == adv[d] - (lat(d) - 1)) begin
        yv = inflight[i].y;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_edge(input int d, input bit rst, input bit hld, input bit ld,
                            input bit iv, input logic [1:0] sel,
                            input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] yv;
    logic [31:0] wm;
    bit          vo;
    if (rst) begin
      adv[d] = 0; op_m[d] = 2'd0; prev_m[d] = '0;
      for (int k = 0; k < 4; k++) cnt_m[d][k] = 0;
      for (int i = inflight.size() - 1; i >= 0; i--)
        if (inflight[i].dut == d) inflight.delete(i);
      return;
    end
    vo = model_vis(d, yv);
    wm = (32'h1 << wd(d)) - 32'h1;
    if (vo && !hld) begin
      for (int k = 0; k < chn(d); k++)
        if (((yv >> (k * wd(d))) & wm) != ((prev_m[d] >> (k * wd(d))) & wm) &&
            cnt_m[d][k] < cmax(d))
          cnt_m[d][k]++;
      prev_m[d] = yv;
    end
    if (!hld) begin
      adv[d]++;
      if (iv) inflight.push_back('{dut: d, stamp: adv[d], y: gate(d, op_m[d], av, bv)});
    end
    if (ld) op_m[d] = sel;
    for (int i = inflight.size() - 1; i >= 0; i--)
      if (inflight[i].dut == d && inflight[i].stamp < adv[d] - (lat(d) - 1))
        inflight.delete(i);
  endtask

  function automatic logic [31:0] dut_y(int d);  return (d == 0) ? 32'(y0) : 32'(y1); endfunction
  function automatic logic dut_ov(int d);        return (d == 0) ? ov0 : ov1;         endfunction
  function automatic logic [1:0] dut_op(int d);  return (d == 0) ? opc0 : opc1;       endfunction
  function automatic int dut_cnt(int d, int k);
    if (d == 0) return int'(ac0[k*CW0 +: CW0]);
    return int'(ac1[k*CW1 +: CW1]);
  endfunction

  // One clock: advance the model with the pre-edge inputs, then settle.
  task automatic tick();
    @(posedge clk);
    model_edge(0, reset0, hold0, op_load0, in_valid0, op_sel0, 32'(a0), 32'(b0));
    model_edge(1, reset1, hold1, op_load1, in_valid1, op_sel1, 32'(a1), 32'(b1));
    #1;
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    reset0 = 1'b1; reset1 = 1'b1; hold0 = 1'b1; op_load0 = 1'b1; op_sel0 = 2'd3; in_valid0 = 1'b1;
    tick(); tick();
    reset0 = 1'b0; reset1 = 1'b0; hold0 = 1'b0; op_load0 = 1'b0; op_sel0 = 2'd0; in_valid0 = 1'b0;
    checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL reset_ov0 got=%b exp=0", ov0); end
    checks++; if (y0 !== 4'h0) begin failures++; $display("FAIL reset_y0 got=%h exp=0", y0); end
    checks++; if (opc0 !== 2'd0) begin failures++; $display("FAIL reset_op0 got=%0d exp=0", opc0); end
    checks++; if (ac0 !== '0) begin failures++; $display("FAIL reset_ac0 got=%h exp=0", ac0); end
    checks++; if (ov1 !== 1'b0 || y1 !== 16'h0 || opc1 !== 2'd0 || ac1 !== '0) begin
      failures++; $display("FAIL reset_dut1 got ov=%b y=%h op=%0d ac=%h exp all 0", ov1, y1, opc1, ac1);
    end
  endtask

  task automatic test_default_or();
    a0 = 4'b0101; b0 = 4'b0011; in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL or_early got=%b exp=0", ov0); end
    tick();
    checks++; if (ov0 !== 1'b1 || y0 !== 4'b0111) begin
      failures++; $display("FAIL or_result got ov=%b y=%b exp ov=1 y=0111", ov0, y0);
    end
    checks++; if (opc0 !== 2'd0) begin failures++; $display("FAIL or_opcur got=%0d exp=0", opc0); end
    tick();
    checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL or_bubble got=%b exp=0", ov0); end
  endtask

  task automatic test_func_switch();
    a0 = 4'b0101; b0 = 4'b0011; in_valid0 = 1'b1; op_load0 = 1'b1; op_sel0 = 2'b10;
    tick();
    op_load0 = 1'b0;
    checks++; if (opc0 !== 2'b10) begin failures++; $display("FAIL sw_opcur got=%b exp=10", opc0); end
    tick();
    in_valid0 = 1'b0;
    checks++; if (ov0 !== 1'b1 || y0 !== 4'b0111) begin
      failures++; $display("FAIL sw_first got ov=%b y=%b exp ov=1 y=0111", ov0, y0);
    end
    tick();
    checks++; if (ov0 !== 1'b1 || y0 !== 4'b0110) begin
      failures++; $display("FAIL sw_second got ov=%b y=%b exp ov=1 y=0110", ov0, y0);
    end
    tick();
  endtask

  task automatic test_hold();
    // Function is XOR here; b=0 passes a straight through.
    b0 = 4'b0000; in_valid0 = 1'b1; a0 = 4'b0001;
    tick();
    a0 = 4'b0010;
    tick();
    checks++; if (ov0 !== 1'b1 || y0 !== 4'b0001) begin
      failures++; $display("FAIL hold_s1 got ov=%b y=%b exp ov=1 y=0001", ov0, y0);
    end
    hold0 = 1'b1; a0 = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (ov0 !== 1'b1 || y0 !== 4'b0001) begin
        failures++; $display("FAIL hold_frozen%0d got ov=%b y=%b exp ov=1 y=0001", i, ov0, y0);
      end
    end
    hold0 = 1'b0; a0 = 4'b0100;
    tick();
    in_valid0 = 1'b0;
    checks++; if (ov0 !== 1'b1 || y0 !== 4'b0010) begin
      failures++; $display("FAIL hold_s2 got ov=%b y=%b exp ov=1 y=0010", ov0, y0);
    end
    tick();
    checks++; if (ov0 !== 1'b1 || y0 !== 4'b0100) begin
      failures++; $display("FAIL hold_s3 got ov=%b y=%b exp ov=1 y=0100", ov0, y0);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL hold_dropped%0d got=%b exp=0", i, ov0); end
    end
  endtask

  task automatic test_reset_midflight();
    a1 = 16'h1234; b1 = 16'h0F0F; in_valid1 = 1'b1; op_load1 = 1'b1; op_sel1 = 2'b10;
    tick();
    op_load1 = 1'b0;
    tick();
    reset1 = 1'b1; in_valid1 = 1'b0; a1 = '0; b1 = '0;
    tick();
    reset1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (ov1 !== 1'b0 || y1 !== 16'h0 || opc1 !== 2'd0) begin
        failures++; $display("FAIL midflight%0d got ov=%b y=%h op=%0d exp ov=0 y=0 op=0", i, ov1, y1, opc1);
      end
    end
  endtask

  task automatic test_wide_nor();
    op_load1 = 1'b1; op_sel1 = 2'b11;
    tick();
    op_load1 = 1'b0;
    in_valid1 = 1'b1; a1 = 16'hF00F; b1 = 16'h0FF0;
    tick();
    a1 = 16'h0000; b1 = 16'h0000;
    tick();
    in_valid1 = 1'b0;
    tick(); tick();
    checks++; if (ov1 !== 1'b1 || y1 !== 16'h0000) begin
      failures++; $display("FAIL nor_first got ov=%b y=%h exp ov=1 y=0000", ov1, y1);
    end
    tick();
    checks++; if (ov1 !== 1'b1 || y1 !== 16'hFFFF) begin
      failures++; $display("FAIL nor_second got ov=%b y=%h exp ov=1 y=ffff", ov1, y1);
    end
    tick();
  endtask

  task automatic test_act_count();
    logic [1:0] exp0;
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0; b1 = '0; in_valid1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a1 = (i % 2 == 0) ? 16'h0055 : 16'h00AA;
      tick();
    end
    in_valid1 = 1'b0; a1 = '0;
    for (int i = 0; i < 6; i++) tick();
`ifdef GATE_ACT_CNT_EN
    exp0 = 2'd3;
`else
    exp0 = 2'd0;
`endif
    checks++; if (ac1[1:0] !== exp0) begin
      failures++; $display("FAIL act_ch0 got=%0d exp=%0d", ac1[1:0], exp0);
    end
    checks++; if (ac1[3:2] !== 2'd0) begin
      failures++; $display("FAIL act_ch1 got=%0d exp=0", ac1[3:2]);
    end
  endtask

  // ---------------- randomized run against the model ----------------
  task automatic test_random();
    logic [31:0] ey;
    bit          ev;
    int          ec;
    for (int n = 0; n < 400; n++) begin
      reset0 = ($urandom_range(0, 59) == 0); reset1 = ($urandom_range(0, 59) == 0);
      hold0 = ($urandom_range(0, 3) == 0);   hold1 = ($urandom_range(0, 3) == 0);
      op_load0 = ($urandom_range(0, 6) == 0); op_load1 = ($urandom_range(0, 6) == 0);
      op_sel0 = 2'($urandom); op_sel1 = 2'($urandom);
      in_valid0 = ($urandom_range(0, 3) != 0); in_valid1 = ($urandom_range(0, 3) != 0);
      a0 = 4'($urandom); b0 = 4'($urandom);
      a1 = 16'($urandom); b1 = 16'($urandom);
      tick();
      for (int d = 0; d < 2; d++) begin
        ev = model_vis(d, ey);
        checks++; if (dut_ov(d) !== ev) begin
          failures++; $display("FAIL rand_ov dut%0d n=%0d got=%b exp=%b", d, n, dut_ov(d), ev);
        end
        if (ev) begin
          checks++; if (dut_y(d) !== ey) begin
            failures++; $display("FAIL rand_y dut%0d n=%0d got=%h exp=%h", d, n, dut_y(d), ey);
          end
        end
        checks++; if (dut_op(d) !== op_m[d]) begin
          failures++; $display("FAIL rand_op dut%0d n=%0d got=%0d exp=%0d", d, n, dut_op(d), op_m[d]);
        end
        for (int k = 0; k < chn(d); k++) begin
`ifdef GATE_ACT_CNT_EN
          ec = cnt_m[d][k];
`else
          ec = 0;
`endif
          checks++; if (dut_cnt(d, k) != ec) begin
            failures++; $display("FAIL rand_act dut%0d ch%0d n=%0d got=%0d exp=%0d", d, k, n, dut_cnt(d, k), ec);
          end
        end
      end
    end
    reset0 = 1'b0; reset1 = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
    op_load0 = 1'b0; op_load1 = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_or();
    test_func_switch();
    test_hold();
    test_reset_midflight();
    test_wide_nor();
    test_act_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/n_channel_gate_array.md
Name: n_channel_gate_array

Overview:
- Parametrised, clocked successor to the quad 2-input gate parts in the 74LSXX library.
- Provides CHANNELS independent 2-operand gates, each operand WIDTH bits wide.
- Gate function is run-time selectable (OR/AND/XOR/NOR), and results come out through a LATENCY-deep valid pipeline with stall.
- Used as the synchronous, FPGA-synthesisable replacement for the gate-delay models in lab designs.

Parameters:
- CHANNELS, 4, number of independent gates (1..16).
- WIDTH, 1, bits per operand per channel (1..32).
- LATENCY, 2, clock cycles from accepted input to valid output (1..16).
- CNT_W, 16, width of each per-channel activity counter (optional feature only).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  CHANNELS*WIDTH  operand A; channel k occupies bits [k*WIDTH +: WIDTH].
- b  input  CHANNELS*WIDTH  operand B; same packing as a.
- op_sel  input  2  function code: 00 OR, 01 AND, 10 XOR, 11 NOR.
- op_load  input  1  latches op_sel into the function register.
- in_valid  input  1  a/b are valid this cycle.
- hold  input  1  stalls the pipeline; all stage contents and out_valid are frozen.
- y  output  CHANNELS*WIDTH  result, packed as a.
- out_valid  output  1  y is valid.
- op_cur  output  2  current function register value.
- act_count  output  CHANNELS*CNT_W  per-channel activity counters (optional feature).

Behaviour:
- Reset, synchronous and active-high. On any clk edge with reset=1:
  - function register = 00 (OR);
  - all pipeline stage data = 0 and stage valid bits = 0;
  - y = 0, out_valid = 0, op_cur = 00, act_count = 0.
  - Reset overrides hold, op_load and in_valid.
  - Reset mid-operation discards all in-flight samples. No output is produced for them.
- Function register:
  - On an edge with op_load=1 and reset=0, the register takes op_sel. op_cur shows the new value from the following cycle.
  - op_load is honoured even while hold=1.
- Stage 0 compute:
  - Per channel, a bitwise function of a and b uses the function register value held before the current edge.
  - Consequence: if op_load and in_valid occur in the same cycle, that sample uses the OLD function.
  - A new function applies only to samples accepted after the op_load cycle. In-flight samples keep the function they were computed with.
- Pipeline:
  - LATENCY stages, each holding CHANNELS*WIDTH data bits plus one valid bit.
  - When hold=0, every stage shifts one place per edge. Stage 0 captures the computed result and in_valid.
  - When hold=1, no stage changes, and in_valid is ignored (the input is dropped, not buffered).
  - y and out_valid are driven directly from the last stage.
  - Sample accepted at edge N with no hold appears with out_valid=1 after edge N+LATENCY-1; for LATENCY=1, y is valid the cycle right after the accepting edge.
  - Each hold cycle adds exactly one cycle of latency to every in-flight sample.
- Bubbles:
  - Invalid slots (in_valid=0) propagate as out_valid=0.
  - y is not required to hold its value during bubbles. Benches compare y only when out_valid=1.
- Throughput: one sample per cycle when hold=0. No back-pressure output.
- Widths: purely bitwise, no carries. Every channel and bit is independent.

Optional Feature:
- Macro: GATE_ACT_CNT_EN.
- Defined: per channel k, act_count[k] increments by 1 on each edge where out_valid=1, hold=0, and that channel's y slice differs from its previous valid output slice.
  - The first valid output after reset counts if it is non-zero; the previous value is 0 at reset.
  - Counters saturate at 2^CNT_W-1.
  - Counters are cleared only by reset.
- Not defined: act_count is tied to 0, and no counter or previous-value registers are synthesised. The port list is unchanged.

Test Plan:
- Reset and default function: reset, then CHANNELS=4, WIDTH=1, a=4'b0101, b=4'b0011, in_valid=1 for 1 cycle, LATENCY=2 -> out_valid=1 one cycle after the accepting edge with y=4'b0111; op_cur=00 throughout.
- Function switch: op_load with op_sel=10 in the same cycle as sample a=0101, b=0011, then a second sample with the same operands -> first output y=0111 (OR), second y=0110 (XOR); op_cur=10 from the cycle after op_load.
- Hold: accept 3 back-to-back samples with results 0001, 0010, 0100, then assert hold for 2 cycles mid-stream -> outputs appear in order, each delayed by exactly 2 extra cycles; in_valid samples during hold produce no output; out_valid is frozen during hold.
- Reset mid-flight: LATENCY=4, accept 2 samples, assert reset on the next edge -> no out_valid for 5 cycles after reset, op_cur=00, y=0.
- Wide and NOR: WIDTH=8, CHANNELS=2, op=11, a=16'hF00F, b=16'h0FF0 -> y=16'h0000; then a=16'h0000, b=16'h0000 -> y=16'hFFFF.
- GATE_ACT_CNT_EN with CNT_W=2: feed alternating results on channel 0 for 5 valid outputs -> act_count[0] saturates at 3; a constant channel 1 with value 0 stays at 0. Without the macro, act_count is always 0.
